mult_booth_acc: RTL and testbench

- Sequential radix-4 Booth multiply-accumulate unit; successor to the shift-add multiplier (mult_sa).
- Retires 2 multiplier bits per cycle. Supports all four two's-complement operand modes.
- Adds valid/ready handshakes on input and output, an optional accumulate mode, and a synchronous flush.
- Sits in the math datapath as a low-area multiplier/MAC for narrow operands.

---
 rtl/mult_booth_acc.sv | 139 +++++++++++++
 tb/tb_mult_booth_acc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_booth_acc.sv
// Sequential radix-4 Booth multiply-accumulate unit: one Booth digit (2 multiplier bits) per cycle,
// valid/ready on both sides, optional accumulation and a synchronous flush.
module mult_booth_acc #(
  parameter int ADw   = 8,
  parameter int BDw   = 4,
  parameter int AccEn = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [1:0]         tc_mode_i,
  input  logic               acc_i,
  input  logic [ADw-1:0]     a_i,
  input  logic [BDw-1:0]     b_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [ADw+BDw-1:0] c_o,
  output logic               busy_o
);

  localparam int PW  = ADw + BDw;
  localparam int BW  = BDw + 1;
  localparam int BWE = BW + (BW % 2);
  localparam int N   = BWE / 2;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [PW-1:0]  acc_q, acc_d;
  logic [PW-1:0]  prod_q, prod_d;
  logic [PW-1:0]  mcand_q, mcand_d;
  logic [BWE-1:0] mult_q, mult_d;
  logic           prev_q, prev_d;
  logic [IW-1:0]  iter_q, iter_d;
  logic           accMode_q, accMode_d;

  logic           accept;
  logic [ADw:0]   aExt;
  logic [BW-1:0]  bExt;
  logic [2:0]     digit;
  logic [PW-1:0]  ppMag;
  logic [PW-1:0]  ppAdd;
  logic [PW-1:0]  prodNext;

  // All arithmetic is modulo 2^PW; the full product always fits, so no wider datapath is needed.
  assign aExt     = {tc_mode_i[0] & a_i[ADw-1], a_i};
  assign bExt     = {tc_mode_i[1] & b_i[BDw-1], b_i};
  assign digit    = {mult_q[1:0], prev_q};
  assign ppAdd    = digit[2] ? ((~ppMag) + PW'(1)) : ppMag;
  assign prodNext = prod_q + ppAdd;

  assign in_ready_o  = (state_q == StIdle) | ((state_q == StDone) & out_ready_i);
  assign accept      = in_valid_i & in_ready_o & ~flush_i;
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q == StCalc);
  assign c_o         = acc_q;

  always_comb begin
    ppMag = '0;
    unique case (digit)
      3'b001, 3'b010, 3'b101, 3'b110: ppMag = mcand_q;
      3'b011, 3'b100:                 ppMag = {mcand_q[PW-2:0], 1'b0};
      default:                        ppMag = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    mult_d    = mult_q;
    prev_d    = prev_q;
    iter_d    = iter_q;
    accMode_d = accMode_q;

    case (state_q)
      StCalc: begin
        prod_d  = prodNext;
        mcand_d = {mcand_q[PW-3:0], 2'b00};
        mult_d  = {2'b00, mult_q[BWE-1:2]};
        prev_d  = mult_q[1];
        iter_d  = iter_q + IW'(1);
        if (iter_q == IW'(N - 1)) begin
          acc_d   = accMode_q ? (acc_q + prodNext) : prodNext;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: ;
    endcase

    if (accept) begin
      mcand_d   = PW'($signed(aExt));
      mult_d    = BWE'($signed(bExt));
      prev_d    = 1'b0;
      prod_d    = '0;
      iter_d    = '0;
      accMode_d = (AccEn != 0) ? acc_i : 1'b0;
      state_d   = StCalc;
    end

    // A flush also blocks a completion landing on the same edge, so the accumulator keeps its last value.
    if (flush_i) begin
      state_d = StIdle;
      acc_d   = acc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      mult_q    <= '0;
      prev_q    <= 1'b0;
      iter_q    <= '0;
      accMode_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      mult_q    <= mult_d;
      prev_q    <= prev_d;
      iter_q    <= iter_d;
      accMode_q <= accMode_d;
    end
  end

endmodule

// File: tb/tb_mult_booth_acc.sv
// Directed bench for mult_booth_acc: a vector table plus hand-written handshake, flush and reset sequences.
// A second instance with AccEn=0 shares all inputs and must always show the plain product.
module tb_mult_booth_acc;

  logic        clk = 1'b0;
  logic        rst, flush, inValid, outReady, accIn;
  logic [1:0]  tcMode;
  logic [7:0]  aIn;
  logic [3:0]  bIn;
  logic        inReady, outValid, busy;
  logic [11:0] c;
  logic        inReady0, outValid0, busy0;
  logic [11:0] c0;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  mult_booth_acc #(.ADw(8), .BDw(4), .AccEn(1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(inValid), .in_ready_o(inReady),
    .tc_mode_i(tcMode), .acc_i(accIn), .a_i(aIn), .b_i(bIn), .out_valid_o(outValid),
    .out_ready_i(outReady), .c_o(c), .busy_o(busy)
  );

  mult_booth_acc #(.ADw(8), .BDw(4), .AccEn(0)) dutNoAcc (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(inValid), .in_ready_o(inReady0),
    .tc_mode_i(tcMode), .acc_i(accIn), .a_i(aIn), .b_i(bIn), .out_valid_o(outValid0),
    .out_ready_i(outReady), .c_o(c0), .busy_o(busy0)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  a;
    logic [3:0]  b;
    logic        acc;
    logic [11:0] expAcc;
    logic [11:0] expPlain;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] golden(input logic [1:0] mode, input logic [7:0] a, input logic [3:0] b);
    int av, bv, p;
    av = mode[0] ? int'($signed(a)) : int'(a);
    bv = mode[1] ? int'($signed(b)) : int'(b);
    p  = av * bv;
    return p[11:0];
  endfunction

  // Presents one operand set for a single edge, then scrambles the operand inputs.
  task automatic startOp(input logic [1:0] mode, input logic [7:0] a, input logic [3:0] b, input logic acc);
    tcMode  = mode;
    aIn     = a;
    bIn     = b;
    accIn   = acc;
    inValid = 1'b1;
    tick;
    inValid = 1'b0;
    aIn     = ~a;
    bIn     = ~b;
    accIn   = ~acc;
  endtask

  // Counts edges from the accept edge until out_valid rises; 20 means the result never came.
  task automatic waitValid(output int lat, output int busyCycles);
    lat        = 0;
    busyCycles = 0;
    while (!outValid && lat < 20) begin
      if (busy) busyCycles++;
      tick;
      lat++;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [7:0] a, input logic [3:0] b, input logic acc,
                               output logic [11:0] res, output logic [11:0] res0, output int lat, output int busyCycles);
    startOp(mode, a, b, acc);
    waitValid(lat, busyCycles);
    res      = c;
    res0     = c0;
    outReady = 1'b1;
    tick;
    outReady = 1'b0;
  endtask

  initial begin
    logic [11:0] res, res0;
    logic [7:0]  aVal;
    int          lat, busyCycles;

    vecs[0]  = '{2'd0, 8'hFF, 4'hF, 1'b0, 12'hEF1, 12'hEF1};
    vecs[1]  = '{2'd3, 8'h80, 4'h8, 1'b0, 12'h400, 12'h400};
    vecs[2]  = '{2'd1, 8'hFF, 4'hF, 1'b0, 12'hFF1, 12'hFF1};
    vecs[3]  = '{2'd2, 8'hFF, 4'hF, 1'b0, 12'hF01, 12'hF01};
    vecs[4]  = '{2'd0, 8'h03, 4'h4, 1'b0, 12'h00C, 12'h00C};
    vecs[5]  = '{2'd0, 8'h05, 4'h6, 1'b1, 12'h02A, 12'h01E};
    vecs[6]  = '{2'd0, 8'hFF, 4'hF, 1'b1, 12'hF1B, 12'hEF1};
    vecs[7]  = '{2'd0, 8'hFF, 4'hF, 1'b0, 12'hEF1, 12'hEF1};
    vecs[8]  = '{2'd0, 8'hFF, 4'hF, 1'b1, 12'hDE2, 12'hEF1};
    vecs[9]  = '{2'd3, 8'h7F, 4'h7, 1'b0, 12'h379, 12'h379};
    vecs[10] = '{2'd3, 8'h80, 4'h7, 1'b0, 12'hC80, 12'hC80};
    vecs[11] = '{2'd2, 8'h10, 4'h8, 1'b0, 12'hF80, 12'hF80};
    vecs[12] = '{2'd1, 8'h80, 4'hF, 1'b0, 12'h880, 12'h880};
    vecs[13] = '{2'd3, 8'hFF, 4'hF, 1'b0, 12'h001, 12'h001};

    rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    accIn = 1'b0; tcMode = 2'd0; aIn = '0; bIn = '0;
    tick;
    tick;
    rst = 1'b0;
    checkOutput("reset c_o", c, 12'h000);
    checkOutput("reset out_valid", outValid, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset in_ready", inReady, 1'b1);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].acc, res, res0, lat, busyCycles);
      checkOutput($sformatf("vec%0d c_o", i), res, vecs[i].expAcc);
      checkOutput($sformatf("vec%0d plain c_o", i), res0, vecs[i].expPlain);
      checkOutput($sformatf("vec%0d latency", i), lat, 3);
    end

    // Backpressure for 5 cycles, then transfer and a new accept on the same edge.
    startOp(2'd0, 8'd2, 4'd3, 1'b0);
    waitValid(lat, busyCycles);
    checkOutput("bp latency", lat, 3);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bp hold c_o %0d", k), c, 12'h006);
      checkOutput($sformatf("bp hold valid %0d", k), outValid, 1'b1);
      checkOutput($sformatf("bp hold in_ready %0d", k), inReady, 1'b0);
      tick;
    end
    outReady = 1'b1; inValid = 1'b1; tcMode = 2'd0; aIn = 8'd4; bIn = 4'd5; accIn = 1'b1;
    #1;
    checkOutput("b2b in_ready", inReady, 1'b1);
    tick;
    outReady = 1'b0; inValid = 1'b0;
    checkOutput("b2b valid dropped", outValid, 1'b0);
    checkOutput("b2b busy", busy, 1'b1);
    waitValid(lat, busyCycles);
    checkOutput("b2b latency", lat, 3);
    checkOutput("b2b c_o", c, 12'h01A);
    checkOutput("b2b plain c_o", c0, 12'h014);
    outReady = 1'b1;
    tick;
    outReady = 1'b0;

    // Flush in the second CALC cycle.
    startOp(2'd0, 8'd7, 4'd7, 1'b1);
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    checkOutput("flush busy", busy, 1'b0);
    checkOutput("flush valid", outValid, 1'b0);
    checkOutput("flush in_ready", inReady, 1'b1);
    checkOutput("flush c_o kept", c, 12'h01A);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("flush no valid %0d", k), outValid, 1'b0);
      tick;
    end
    flush = 1'b1; inValid = 1'b1; tcMode = 2'd0; aIn = 8'd9; bIn = 4'd9; accIn = 1'b0;
    tick;
    flush = 1'b0; inValid = 1'b0;
    checkOutput("flush beats accept", busy, 1'b0);
    applyStimulus(2'd0, 8'd1, 4'd1, 1'b1, res, res0, lat, busyCycles);
    checkOutput("post-flush acc c_o", res, 12'h01B);
    checkOutput("post-flush plain c_o", res0, 12'h001);

    // Reset in the middle of CALC.
    startOp(2'd0, 8'd9, 4'd9, 1'b0);
    tick;
    rst = 1'b1;
    tick;
    checkOutput("mid reset valid", outValid, 1'b0);
    checkOutput("mid reset busy", busy, 1'b0);
    checkOutput("mid reset c_o", c, 12'h000);
    checkOutput("mid reset plain c_o", c0, 12'h000);
    rst = 1'b0;
    applyStimulus(2'd0, 8'd2, 4'd3, 1'b1, res, res0, lat, busyCycles);
    checkOutput("post-reset acc c_o", res, 12'h006);
    checkOutput("post-reset latency", lat, 3);

    // Sweep of all modes and multipliers over a spread of multiplicands.
    for (int m = 0; m < 4; m++) begin
      for (int ai = 0; ai < 18; ai++) begin
        aVal = (ai < 16) ? 8'(ai * 17) : ((ai == 16) ? 8'h80 : 8'h7F);
        for (int bi = 0; bi < 16; bi++) begin
          applyStimulus(2'(m), aVal, 4'(bi), 1'b0, res, res0, lat, busyCycles);
          checkOutput($sformatf("sweep m%0d a%0h b%0h c_o", m, aVal, bi), res, golden(2'(m), aVal, 4'(bi)));
          checkOutput($sformatf("sweep m%0d a%0h b%0h plain", m, aVal, bi), res0, golden(2'(m), aVal, 4'(bi)));
          checkOutput($sformatf("sweep m%0d a%0h b%0h latency", m, aVal, bi), lat, 3);
          checkOutput($sformatf("sweep m%0d a%0h b%0h busy", m, aVal, bi), busyCycles, 3);
        end
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
